// File: rtl/wash_program_ctrl.sv
// Washing-machine program sequencer.
// Runs IDLE -> FILL -> WASH -> DRAIN -> FILL -> RINSE -> DRAIN -> SPIN -> DONE -> IDLE,
// with fill/drain sensor timeouts latching ERROR and abort returning to IDLE.
// Ports:
//   clk, rst_n        1 Hz clock, asynchronous active-low reset
//   start, abort      program request (IDLE only) / cancel or clear error
//   level_full/empty  tub level sensors
//   agit_compl_n      agitation sequencer status, falling edge = one cycle finished
//   agit_start        one-cycle launch pulse for one agitation cycle
//   fill_valve, drain_pump, spin   actuators
//   busy, done, error status; phase = current state code
module wash_program_ctrl #(
  parameter int unsigned WASH_REPS     = 3,
  parameter int unsigned RINSE_REPS    = 2,
  parameter int unsigned FILL_TIMEOUT  = 60,
  parameter int unsigned DRAIN_TIMEOUT = 60,
  parameter int unsigned SPIN_TIME     = 30,
  parameter int unsigned TW            = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       level_full,
  input  logic       level_empty,
  input  logic       agit_compl_n,
  output logic       agit_start,
  output logic       fill_valve,
  output logic       drain_pump,
  output logic       spin,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StWash  = 3'd2,
    StDrain = 3'd3,
    StRinse = 3'd4,
    StSpin  = 3'd5,
    StDone  = 3'd6,
    StError = 3'd7
  } state_e;

  localparam logic [TW-1:0] FillLast  = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] DrainLast = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [TW-1:0] SpinLast  = TW'(SPIN_TIME - 1);
  localparam logic [3:0]    WashTgt   = 4'(WASH_REPS);
  localparam logic [3:0]    RinseTgt  = 4'(RINSE_REPS);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    rep_q, rep_d;
  logic          rinse_q, rinse_d;
  logic          agit_prev_q;

  logic agit_start_q, agit_start_d;
  logic fill_valve_q, fill_valve_d;
  logic drain_pump_q, drain_pump_d;
  logic spin_q, spin_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic       fall;
  logic       agitating;
  logic [3:0] rep_inc;
  logic [3:0] rep_tgt;

  assign fall      = agit_prev_q & ~agit_compl_n;
  assign agitating = (state_q == StWash) || (state_q == StRinse);
  assign rep_inc   = rep_q + 4'd1;
  assign rep_tgt   = (state_q == StRinse) ? RinseTgt : WashTgt;

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    rinse_d = rinse_q;

    unique case (state_q)
      StIdle: begin
        rinse_d = 1'b0;
        if (start && !abort) state_d = StFill;
      end
      StFill: begin
        // Sensor is checked before the timeout so it wins a same-cycle tie.
        if (abort)                     state_d = StIdle;
        else if (level_full)           state_d = rinse_q ? StRinse : StWash;
        else if (timer_q >= FillLast)  state_d = StError;
      end
      StWash, StRinse: begin
        if (abort) begin
          state_d = StIdle;
        end else if (fall) begin
          rep_d = rep_inc;
          if (rep_inc >= rep_tgt) state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else if (level_empty) begin
          if (rinse_q) begin
            state_d = StSpin;
          end else begin
            state_d = StFill;
            rinse_d = 1'b1;
          end
        end else if (timer_q >= DrainLast) begin
          state_d = StError;
        end
      end
      StSpin: begin
        if (abort)                   state_d = StIdle;
        else if (timer_q >= SpinLast) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      StError: begin
        if (abort) state_d = StIdle;
      end
    endcase

    // Timer and rep counter restart on every state change; timer saturates.
    if (state_d != state_q) begin
      rep_d   = 4'd0;
      timer_d = '0;
    end else if (((state_q == StFill) || (state_q == StDrain) || (state_q == StSpin)) &&
                 (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end

    // Launch on entry, then once after each completed cycle still short of the target.
    agit_start_d = 1'b0;
    if (((state_d == StWash) || (state_d == StRinse)) && (state_d != state_q)) begin
      agit_start_d = 1'b1;
    end
    if (agitating && (state_d == state_q) && fall && (rep_inc < rep_tgt)) begin
      agit_start_d = 1'b1;
    end

    // Outputs are registered versions of the next-state decode.
    fill_valve_d = (state_d == StFill);
    drain_pump_d = (state_d == StDrain) || (state_d == StSpin);
    spin_d       = (state_d == StSpin);
    busy_d       = (state_d != StIdle) && (state_d != StError);
    done_d       = (state_d == StDone);
    error_d      = (state_d == StError);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      rep_q        <= 4'd0;
      rinse_q      <= 1'b0;
      agit_prev_q  <= 1'b1;
      agit_start_q <= 1'b0;
      fill_valve_q <= 1'b0;
      drain_pump_q <= 1'b0;
      spin_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rep_q        <= rep_d;
      rinse_q      <= rinse_d;
      agit_prev_q  <= agit_compl_n;
      agit_start_q <= agit_start_d;
      fill_valve_q <= fill_valve_d;
      drain_pump_q <= drain_pump_d;
      spin_q       <= spin_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign agit_start = agit_start_q;
  assign fill_valve = fill_valve_q;
  assign drain_pump = drain_pump_q;
  assign spin       = spin_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_wash_program_ctrl.sv
// Scoreboard bench for wash_program_ctrl: stimulus pushes expected phase transitions
// (new phase, dwell of the previous phase, agit_start pulses seen in it); a monitor pops
// and compares on every phase change and checks per-cycle output decoding.
module tb_wash_program_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       level_full = 1'b0;
  logic       level_empty = 1'b1;
  logic       agit_compl_n = 1'b0;
  logic       agit_start, fill_valve, drain_pump, spin, busy, done, error;
  logic [2:0] phase;

  always #5 clk = ~clk;

  wash_program_ctrl #(
    .WASH_REPS    (2),
    .RINSE_REPS   (1),
    .FILL_TIMEOUT (8),
    .DRAIN_TIMEOUT(8),
    .SPIN_TIME    (4),
    .TW           (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .level_full  (level_full),
    .level_empty (level_empty),
    .agit_compl_n(agit_compl_n),
    .agit_start  (agit_start),
    .fill_valve  (fill_valve),
    .drain_pump  (drain_pump),
    .spin        (spin),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .phase       (phase)
  );

  typedef struct {
    int ph;
    int dwell;
    int agit;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   tmo_req = 0;

  // Environment model state (main process only).
  int fill_delay = 3;
  int fcnt = 0;
  int dcnt = 0;
  int acnt = 0;

  function automatic void chk(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endfunction

  function automatic void push(int p, int d, int a);
    exp_t e;
    e.ph    = p;
    e.dwell = d;
    e.agit  = a;
    exp_q.push_back(e);
  endfunction

  // One clock of environment: tub sensors reply after a fill/drain delay, and the
  // agitation sequencer drops agit_compl_n five negedges after seeing agit_start.
  task automatic step();
    @(negedge clk);
    if (fill_valve) begin
      fcnt++;
      level_empty = 1'b0;
    end else begin
      fcnt = 0;
    end
    if (drain_pump) begin
      dcnt++;
      level_full = 1'b0;
    end else begin
      dcnt = 0;
      if (fcnt >= fill_delay) level_full = 1'b1;
    end
    if (dcnt >= 3) level_empty = 1'b1;
    if (agit_start) begin
      agit_compl_n = 1'b1;
      acnt = 0;
    end else if (agit_compl_n) begin
      acnt++;
      if (acnt >= 5) agit_compl_n = 1'b0;
    end
  endtask

  task automatic env_reset();
    level_full   = 1'b0;
    level_empty  = 1'b1;
    agit_compl_n = 1'b0;
    fcnt = 0;
    dcnt = 0;
    acnt = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_q(int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) return;
      step();
    end
    tmo_req++;
    exp_q.delete();
  endtask

  task automatic wait_phase(int p, int bound);
    for (int i = 0; i < bound; i++) begin
      if (int'(phase) == p) return;
      step();
    end
    tmo_req++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    int   cur;
    int   dwell;
    int   agit;
    int   tmo_ack;
    exp_t e;
    logic [5:0] got;
    logic [5:0] want;
    cur = 0;
    dwell = 0;
    agit = 0;
    tmo_ack = 0;
    forever begin
      @(negedge clk);
      got  = {fill_valve, drain_pump, spin, busy, error, done};
      want = {phase == 3'd1, (phase == 3'd3) || (phase == 3'd5), phase == 3'd5,
              (phase != 3'd0) && (phase != 3'd7), phase == 3'd7, phase == 3'd6};
      chk("outputs_vs_phase", int'(got), int'(want));
      chk("agit_start_outside_agitation",
          int'(agit_start && (phase != 3'd2) && (phase != 3'd4)), 0);
      chk("fill_and_drain_together", int'(fill_valve & drain_pump), 0);
      if (!rst_n) chk("reset_outputs", int'({agit_start, got, phase}), 0);
      if (int'(phase) != cur) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_phase_change", int'(phase), cur);
        end else begin
          e = exp_q.pop_front();
          chk("phase_sequence", int'(phase), e.ph);
          if (e.dwell >= 0) chk($sformatf("dwell_in_phase_%0d", cur), dwell, e.dwell);
          if (e.agit >= 0) chk($sformatf("agit_pulses_in_phase_%0d", cur), agit, e.agit);
        end
        cur   = int'(phase);
        dwell = 1;
        agit  = int'(agit_start);
      end else begin
        dwell++;
        agit += int'(agit_start);
      end
      if (tmo_req != tmo_ack) begin
        chk("wait_bound_expired", tmo_req, tmo_ack);
        tmo_ack = tmo_req;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Power-on reset (explicit falling edge so the async branch fires).
    #1 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Full program with 3-cycle sensor replies.
    env_reset();
    fill_delay = 3;
    push(1, -1, 0); push(2, 3, 0); push(3, 12, 2); push(1, 3, 0); push(4, 3, 0);
    push(3, 6, 1);  push(5, 3, 0); push(6, 4, 0);  push(0, 1, 0);
    pulse_start();
    wait_q(200);
    idle(4);

    // Fill timeout -> ERROR, then abort clears it.
    env_reset();
    fill_delay = 99;
    push(1, -1, 0); push(7, 8, 0);
    pulse_start();
    wait_q(40);
    idle(3);
    push(0, -1, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_q(10);
    idle(2);

    // level_full arrives exactly on the timeout cycle: sensor wins.
    env_reset();
    fill_delay = 8;
    push(1, -1, 0); push(2, 8, 0); push(3, 12, 2); push(1, 3, 0); push(4, 8, 0);
    push(3, 6, 1);  push(5, 3, 0); push(6, 4, 0);  push(0, 1, 0);
    pulse_start();
    wait_q(250);
    idle(4);

    // Abort in WASH right after the first agit_start.
    env_reset();
    fill_delay = 3;
    push(1, -1, 0); push(2, 3, 0);
    pulse_start();
    begin : find_agit
      for (int i = 0; i < 30; i++) begin
        step();
        if (agit_start) disable find_agit;
      end
      tmo_req++;
    end
    push(0, 1, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_q(10);
    idle(8);

    // Asynchronous reset in SPIN with start held high through reset.
    env_reset();
    fill_delay = 3;
    push(1, -1, 0); push(2, 3, 0); push(3, 12, 2); push(1, 3, 0); push(4, 3, 0);
    push(3, 6, 1);  push(5, 3, 0);
    pulse_start();
    wait_phase(5, 200);
    @(posedge clk);
    #2;
    push(0, -1, -1);
    rst_n = 1'b0;
    start = 1'b1;
    idle(3);
    push(1, -1, 0);
    rst_n = 1'b1;
    step();
    push(0, 1, 0);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_q(10);
    idle(3);

    // start+abort together stays IDLE; then tub already full gives 1-cycle FILL.
    env_reset();
    start = 1'b1;
    abort = 1'b1;
    idle(3);
    start = 1'b0;
    abort = 1'b0;
    step();
    fill_delay = 0;
    step();
    push(1, -1, 0); push(2, 1, 0); push(3, 12, 2); push(1, 3, 0); push(4, 1, 0);
    push(3, 6, 1);  push(5, 3, 0); push(6, 4, 0);  push(0, 1, 0);
    pulse_start();
    wait_q(200);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
